// File: rtl/uart_pkg.sv
// Shared receiver FSM encoding and bit-timing helper.
// Build option: UART_RX_PARITY_EN adds the S_PARITY state.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } rx_state_t;

    function automatic int calc_bit_limit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Power-of-2 circular receive buffer; a pushed word is visible on data the next cycle.
// A push while full is refused unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [Width-1:0]           wdata,
    input  logic                       pop,
    output logic [Width-1:0]           data,
    output logic [$clog2(Depth):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] CntFull = (AW+1)'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CntFull);
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)
                r_count <= r_count + 1'b1;
            else if (w_pop_ok && !w_push_ok)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
    end

    // Empty slots read as zero so rx_data is clean out of reset.
    assign data  = empty ? '0 : r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start-bit mid-sampling, LSB-first data, byte buffered one cycle after stop sample.
// Backpressure via rx_ready pops; a full buffer drops the new byte and pulses overflow. Option: UART_RX_PARITY_EN.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BAUD      = 9600,
    parameter int CLK_FREQ  = 100_000_000,
    parameter int DataWidth = 8,
    parameter int FifoDepth = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx,
    input  logic                         rx_ready,
    output logic [DataWidth-1:0]         rx_data,
    output logic                         rx_valid,
    output logic [$clog2(FifoDepth):0]   rx_count,
    output logic                         frame_err,
    output logic                         overflow
);
    localparam int BitLimit  = calc_bit_limit(CLK_FREQ, BAUD);
    localparam int HalfLimit = BitLimit / 2;
    localparam int TW        = $clog2(BitLimit + 1);
    localparam int CW        = $clog2(DataWidth + 1);
    localparam logic [TW-1:0] BitLast  = TW'(BitLimit - 1);
    localparam logic [TW-1:0] HalfLast = TW'(HalfLimit - 1);
    localparam logic [CW-1:0] CntLast  = CW'(DataWidth - 1);

    logic [1:0]           r_sync;
    rx_state_t            r_state, w_state_nxt;
    logic [TW-1:0]        r_timer, w_timer_nxt;
    logic [CW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [DataWidth-1:0] r_shift, w_shift_nxt;
    logic                 r_stop_err, w_stop_err_nxt;
    logic                 r_frame_err, r_overflow;
    logic                 w_rx_s, w_push, w_ferr, w_full, w_empty, w_par_ok;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit, w_par_bit_nxt;
    assign w_par_ok = ~^{r_shift, r_par_bit};
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_rx_s = r_sync[1];

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer + 1'b1;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_stop_err_nxt = r_stop_err;
        w_push         = 1'b0;
        w_ferr         = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bit_nxt  = r_par_bit;
`endif
        case (r_state)
            S_IDLE: begin
                w_timer_nxt    = '0;
                w_bit_cnt_nxt  = '0;
                w_stop_err_nxt = 1'b0;
                if (!w_rx_s) w_state_nxt = S_START;
            end
            S_START: if (r_timer == HalfLast) begin
                w_timer_nxt = '0;
                w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (r_timer == BitLast) begin
                w_timer_nxt   = '0;
                w_shift_nxt   = {w_rx_s, r_shift[DataWidth-1:1]};
                w_bit_cnt_nxt = r_bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (r_bit_cnt == CntLast) w_state_nxt = S_PARITY;
`else
                if (r_bit_cnt == CntLast) w_state_nxt = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (r_timer == BitLast) begin
                w_timer_nxt   = '0;
                w_par_bit_nxt = w_rx_s;
                w_state_nxt   = S_STOP;
            end
`endif
            S_STOP: begin
                // Only the first stop-bit sample matters; leaving mid-bit allows back-to-back frames.
                if (r_stop_err) begin
                    if (w_rx_s) w_state_nxt = S_IDLE;
                end else if (r_timer == BitLast) begin
                    if (w_rx_s && w_par_ok) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr = 1'b1;
                        if (w_rx_s) w_state_nxt    = S_IDLE;
                        else        w_stop_err_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= 2'b11;
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_stop_err  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
`endif
        end else begin
            r_sync      <= {r_sync[0], rx};
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_stop_err  <= w_stop_err_nxt;
            r_frame_err <= w_ferr;
            r_overflow  <= w_push && w_full && !rx_ready;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= w_par_bit_nxt;
`endif
        end
    end

    uart_rx_fifo #(
        .Width (DataWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_shift_nxt),
        .pop   (rx_ready),
        .data  (rx_data),
        .count (rx_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rx_valid  = !w_empty;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule
